// File: rtl/regs_pkg.sv
// rtl/regs_pkg.sv - shared constants and types for the integer register file
package regs_pkg;

    localparam int XLEN_RV32      = 32;
    localparam int NUM_REGS_RV32I = 32;
    localparam int NUM_REGS_RV32E = 16;
    localparam int REG_ZERO       = 0;

    typedef logic [$clog2(NUM_REGS_RV32I)-1:0] reg_addr_t;
    typedef logic [XLEN_RV32-1:0]              data_word_t;

endpackage

// File: rtl/regs_sb_scoreboard.sv
// rtl/regs_sb_scoreboard.sv - pending-write scoreboard with per-port busy lookup
module regs_sb_scoreboard
    import regs_pkg::*;
#(
    parameter int  NUM_REGS     = NUM_REGS_RV32I,
    parameter int  NUM_RD_PORTS = 2,
    parameter int  BYPASS       = 1,
    localparam int AW           = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD_PORTS*AW-1:0] rs_addr,
    input  logic                       rd_wr_en,
    input  logic [AW-1:0]              rd,
    input  logic                       issue_en,
    input  logic [AW-1:0]              issue_rd,
    input  logic                       flush,
    output logic [NUM_RD_PORTS-1:0]    rs_busy
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                retire;
    logic                issue;

    assign retire = rd_wr_en && (rd != AW'(REG_ZERO));
    assign issue  = issue_en && (issue_rd != AW'(REG_ZERO));

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else begin
            if (retire) pending_d[rd]       = 1'b0;
            if (issue)  pending_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_busy
        logic [AW-1:0] addr;
        logic          fwd;
        assign addr = rs_addr[i*AW +: AW];
        // A value retiring this cycle is forwarded, so the source is no longer a hazard.
        assign fwd  = (BYPASS != 0) && retire && (rd == addr);
        assign rs_busy[i] = (addr != AW'(REG_ZERO)) && pending_q[addr] && !fwd;
    end

endmodule

// File: rtl/regs_sb.sv
// rtl/regs_sb.sv - parametrised register file with registered reads, write bypass and scoreboard
module regs_sb
    import regs_pkg::*;
#(
    parameter int  XLEN         = XLEN_RV32,
    parameter int  NUM_REGS     = NUM_REGS_RV32I,
    parameter int  NUM_RD_PORTS = 2,
    parameter int  BYPASS       = 1,
    parameter int  RESET_REGS   = 1,
    localparam int AW           = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rs_rd_en,
    input  logic [NUM_RD_PORTS*AW-1:0]   rs_addr,
    output logic [NUM_RD_PORTS*XLEN-1:0] rs_rd_data,
    output logic [NUM_RD_PORTS-1:0]      rs_busy,
    input  logic                         rd_wr_en,
    input  logic [AW-1:0]                rd,
    input  logic [XLEN-1:0]              rd_wr_data,
    input  logic                         issue_en,
    input  logic [AW-1:0]                issue_rd,
    input  logic                         flush
);

    logic [XLEN-1:0]              regs_q [NUM_REGS];
    logic [NUM_RD_PORTS*XLEN-1:0] rd_data_q;
    logic [NUM_RD_PORTS*XLEN-1:0] rd_data_d;
    logic [AW-1:0]                port_addr [NUM_RD_PORTS];
    logic                         wr_en;

    assign wr_en = rd_wr_en && (rd != AW'(REG_ZERO));

    if (RESET_REGS != 0) begin : g_rst_regs
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs_q[r] <= '0;
                end
            end else if (wr_en) begin
                regs_q[rd] <= rd_wr_data;
            end
        end
    end else begin : g_ram_regs
        always_ff @(posedge clk) begin
            if (wr_en) begin
                regs_q[rd] <= rd_wr_data;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_port_addr
        assign port_addr[i] = rs_addr[i*AW +: AW];
    end

    // x0 is forced to zero on read, so its storage entry is never relied upon.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rs_rd_en) begin
            for (int i = 0; i < NUM_RD_PORTS; i++) begin
                if (port_addr[i] == AW'(REG_ZERO)) begin
                    rd_data_d[i*XLEN +: XLEN] = '0;
                end else if ((BYPASS != 0) && wr_en && (rd == port_addr[i])) begin
                    rd_data_d[i*XLEN +: XLEN] = rd_wr_data;
                end else begin
                    rd_data_d[i*XLEN +: XLEN] = regs_q[port_addr[i]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rs_rd_data = rd_data_q;

    regs_sb_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .NUM_RD_PORTS (NUM_RD_PORTS),
        .BYPASS       (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rd_wr_en (rd_wr_en),
        .rd       (rd),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .rs_busy  (rs_busy)
    );

endmodule
